// File: rtl/qpsk_uart_tx.sv
// qpsk_uart_tx: drains demapped characters from the QPSK demapper FIFO and
// sends each one as an 8N1 UART frame (LSB first) on tx. It counts the frames
// that complete and pulses eom when a 0x00 terminator byte finishes sending.
// Every output is registered. Each output is taken from the next-state
// decode, so tx, busy and read_en change on the same edge as the state.
module qpsk_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [7:0]       data_in,
    output logic             read_en,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] char_cnt,
    output logic             eom
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    // Last value of the bit timer within one UART bit period.
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    // A 0x00 byte marks the end of a message.
    function automatic logic is_terminator(input logic [7:0] b);
        return (b == 8'h00);
    endfunction

    state_t             state_r, state_s;
    logic [7:0]         shift_r, shift_s;
    logic [15:0]        timer_r, timer_s;
    logic [2:0]         bit_r, bit_s;
    logic               zero_r, zero_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               tx_r, tx_s;
    logic               read_en_r, read_en_s;
    logic               busy_r, busy_s;
    logic               eom_r, eom_s;
    logic               bit_end_s;

    assign bit_end_s = (timer_r == BIT_LAST);

    // Next-state, datapath and next-output decode for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        timer_s   = timer_r;
        bit_s     = bit_r;
        zero_s    = zero_r;
        cnt_s     = cnt_r;
        eom_s     = 1'b0;
        tx_s      = 1'b1;
        read_en_s = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && !empty) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                state_s = LATCH;
            end
            LATCH: begin
                // The FIFO word is valid now, one cycle after the pop.
                shift_s = data_in;
                zero_s  = is_terminator(data_in);
                timer_s = 16'd0;
                bit_s   = 3'd0;
                state_s = START;
            end
            START: begin
                if (bit_end_s) begin
                    timer_s = 16'd0;
                    state_s = DATA;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    timer_s = 16'd0;
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    timer_s = 16'd0;
                    cnt_s   = cnt_r + CNT_W'(1);
                    eom_s   = zero_r;
                    // Chain straight into the next pop when more data waits.
                    if (en && !empty) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase
        read_en_s = (state_s == FETCH);
        busy_s    = (state_s != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= 8'h00;
            timer_r   <= 16'd0;
            bit_r     <= 3'd0;
            zero_r    <= 1'b0;
            cnt_r     <= '0;
            tx_r      <= 1'b1;
            read_en_r <= 1'b0;
            busy_r    <= 1'b0;
            eom_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            timer_r   <= timer_s;
            bit_r     <= bit_s;
            zero_r    <= zero_s;
            cnt_r     <= cnt_s;
            tx_r      <= tx_s;
            read_en_r <= read_en_s;
            busy_r    <= busy_s;
            eom_r     <= eom_s;
        end
    end

    assign read_en  = read_en_r;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign char_cnt = cnt_r;
    assign eom      = eom_r;

endmodule

// File: tb/tb_qpsk_uart_tx.sv
// Testbench for qpsk_uart_tx. A FIFO model feeds the DUT. An inline UART
// receiver decodes tx and checks each byte against a queue of expected bytes.
module tb_qpsk_uart_tx;

    localparam int CPB   = 16;
    localparam int CW    = 16;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          empty;
    logic [7:0]    data_in = 8'h00;
    logic          read_en;
    logic          tx;
    logic          busy;
    logic [CW-1:0] char_cnt;
    logic          eom;

    qpsk_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .empty    (empty),
        .data_in  (data_in),
        .read_en  (read_en),
        .tx       (tx),
        .busy     (busy),
        .char_cnt (char_cnt),
        .eom      (eom)
    );

    always #5 clk = ~clk;

    // FIFO model: the main process writes, and the monitor below pops on read_en.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    int cyc       = 0;
    int rd_pulses = 0;
    int viol      = 0;
    int eom_hi    = 0;
    int busy_cyc  = 0;
    int tx_low    = 0;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts DUT activity and serves FIFO pops.
    always @(negedge clk) begin
        if (!reset) begin
            if (read_en) begin
                rd_pulses <= rd_pulses + 1;
                if (wr_ptr == rd_ptr) begin
                    viol <= viol + 1;
                end else begin
                    data_in <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + 1;
                end
            end
            if (eom)  eom_hi   <= eom_hi + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (!tx)  tx_low   <= tx_low + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait (bounded) for the falling edge of a start bit, sampled on negedges.
    task automatic wait_tx_low(output int st, output bit ok);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (tx === 1'b0);
        st = cyc;
    endtask

    // Receive one 8N1 frame, sampling each bit at its middle.
    task automatic rx_frame(output logic [7:0] b, output int st, output bit ok);
        bit found, s_ok, p_ok;
        b = 8'h00;
        wait_tx_low(st, found);
        if (!found) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        s_ok = (tx === 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        p_ok = (tx === 1'b1);
        ok = s_ok && p_ok;
    endtask

    // Pop the scoreboard and compare it with a decoded byte.
    task automatic score(input string name, input logic [7:0] got);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'd0, got}, {24'd0, e});
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         eom_cum;
    } vec_t;

    vec_t       tbl [3];
    logic [7:0] msg [8];

    initial begin
        logic [7:0] b;
        int st, prev_st, t0;
        bit ok;
        int s_rd, s_eom, s_busy, s_txl, s_cnt, n;

        tbl[0] = '{data: 8'h48, eom_cum: 0};
        tbl[1] = '{data: 8'h69, eom_cum: 0};
        tbl[2] = '{data: 8'h00, eom_cum: 1};
        msg = '{8'h51, 8'h50, 8'h53, 8'h4B, 8'h20, 8'h6F, 8'h6B, 8'h00};

        // Reset values
        reset = 1'b1;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_read_en", {31'd0, read_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_char_cnt", {16'd0, char_cnt}, 32'd0);
        check("rst_eom", {31'd0, eom}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during DATA bit 3 abandons the frame
        s_rd = rd_pulses;
        push(8'h5A);
        en = 1'b1;
        wait_tx_low(st, ok);
        check("abort_start_seen", {31'd0, ok}, 32'd1);
        repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        check("abort_bit3", {31'd0, tx}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_char_cnt", {16'd0, char_cnt}, 32'd0);
        check("abort_reads", rd_pulses - s_rd, 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 'A' after reset release
        s_rd = rd_pulses; s_eom = eom_hi; s_busy = busy_cyc;
        t0 = cyc;
        push(8'h41);
        exp_q.push_back(8'h41);
        rx_frame(b, st, ok);
        check("a_frame_ok", {31'd0, ok}, 32'd1);
        check("a_latency", st - t0, 32'd3);
        score("a_data", b);
        repeat (12) @(negedge clk);
        check("a_char_cnt", {16'd0, char_cnt}, 32'd1);
        check("a_reads", rd_pulses - s_rd, 32'd1);
        check("a_eom", eom_hi - s_eom, 32'd0);
        check("a_busy_len", busy_cyc - s_busy, FRAME + 2);
        check("a_busy_end", {31'd0, busy}, 32'd0);

        // Empty and en gating
        s_rd = rd_pulses; s_txl = tx_low;
        repeat (100) @(negedge clk);
        check("gate_empty_reads", rd_pulses - s_rd, 32'd0);
        check("gate_empty_txlow", tx_low - s_txl, 32'd0);
        en = 1'b0;
        push(8'hFF);
        @(negedge clk);
        push(8'h33);
        repeat (50) @(negedge clk);
        check("gate_en0_reads", rd_pulses - s_rd, 32'd0);
        check("gate_en0_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'hFF);
        en = 1'b1;
        n = 0;
        while (rd_pulses == s_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        rx_frame(b, st, ok);
        check("drop_frame_ok", {31'd0, ok}, 32'd1);
        score("drop_data", b);
        repeat (40) @(negedge clk);
        check("drop_idle_busy", {31'd0, busy}, 32'd0);
        check("drop_reads", rd_pulses - s_rd, 32'd1);
        check("drop_char_cnt", {16'd0, char_cnt}, 32'd2);
        exp_q.push_back(8'h33);
        en = 1'b1;
        rx_frame(b, st, ok);
        check("drain_frame_ok", {31'd0, ok}, 32'd1);
        score("drain_data", b);
        repeat (20) @(negedge clk);

        // Back-to-back 'H','i',0x00, table driven
        en = 1'b0;
        s_rd = rd_pulses; s_eom = eom_hi; s_cnt = char_cnt;
        for (int i = 0; i < 3; i++) begin
            push(tbl[i].data);
            exp_q.push_back(tbl[i].data);
        end
        @(negedge clk);
        en = 1'b1;
        prev_st = 0;
        for (int i = 0; i < 3; i++) begin
            rx_frame(b, st, ok);
            check($sformatf("b2b_ok_%0d", i), {31'd0, ok}, 32'd1);
            score($sformatf("b2b_data_%0d", i), b);
            if (i > 0) check($sformatf("b2b_gap_%0d", i), st - prev_st, FRAME + 2);
            prev_st = st;
            repeat (CPB / 2 + 1) @(negedge clk);
            check($sformatf("b2b_eom_%0d", i), eom_hi - s_eom, tbl[i].eom_cum);
            check($sformatf("b2b_cnt_%0d", i), char_cnt - s_cnt, i + 1);
        end
        repeat (20) @(negedge clk);
        check("b2b_reads", rd_pulses - s_rd, 32'd3);

        // Message trickling into the FIFO every 3 cycles
        s_cnt = char_cnt; s_eom = eom_hi;
        for (int i = 0; i < 8; i++) exp_q.push_back(msg[i]);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    push(msg[i]);
                    repeat (3) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    rx_frame(b, st, ok);
                    check($sformatf("msg_ok_%0d", i), {31'd0, ok}, 32'd1);
                    score($sformatf("msg_data_%0d", i), b);
                end
            end
        join
        repeat (20) @(negedge clk);
        check("msg_char_cnt", char_cnt - s_cnt, 32'd8);
        check("msg_eom", eom_hi - s_eom, 32'd1);
        check("read_while_empty", viol, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
